// File: rtl/vm_dispense_ctrl.sv
// Vending machine dispense controller: queues vend/change events from the
// coin-accept FSM and drives the bottle motor and the 5rs coin hopper.
module vm_dispense_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MOTOR_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_i,
    input  logic [1:0] change_i,
    input  logic       coin_ack,
    output logic       motor_on,
    output logic       coin_req,
    output logic       busy,
    output logic       overflow,
    output logic       bad_code,
    output logic       fault,
    output logic [7:0] bottles_cnt,
    output logic [7:0] coins_cnt
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned MCNT_W = $clog2(MOTOR_CYCLES + 1);
    localparam int unsigned WCNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned ENT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_COIN_REQ,
        S_COIN_REL,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [MCNT_W-1:0]  mcnt_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic [1:0]         coins_left_q;

    logic [1:0]         ev_coins_c;
    logic               event_c;
    logic               full_c;
    logic               push_c;
    logic               pop_c;
    logic [ENT_W-1:0]   head_c;
    logic               head_vend_c;
    logic [1:0]         head_coins_c;

    // Event decode and FIFO push/pop qualification
    always_comb begin
        ev_coins_c   = 2'd0;
        if (change_i == 2'b01) ev_coins_c = 2'd1;
        if (change_i == 2'b10) ev_coins_c = 2'd2;
        event_c      = vend_i | (ev_coins_c != 2'd0);
        full_c       = (count_q == CNT_W'(FIFO_DEPTH));
        push_c       = event_c & ~full_c;
        pop_c        = (state_q == S_IDLE) && (count_q != '0);
        head_c       = mem_q[rd_ptr_q];
        head_vend_c  = head_c[2];
        head_coins_c = head_c[1:0];
        count_d      = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Event FIFO storage and pointers; full-check uses the pre-edge count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= {vend_i, ev_coins_c};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Next-state decode for the actuator sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    if (head_vend_c)
                        state_d = S_MOTOR;
                    else if (head_coins_c != 2'd0)
                        state_d = S_COIN_REQ;
                end
            end
            S_MOTOR: begin
                if (mcnt_q == MCNT_W'(MOTOR_CYCLES - 1))
                    state_d = (coins_left_q != 2'd0) ? S_COIN_REQ : S_IDLE;
            end
            S_COIN_REQ: begin
                if (coin_ack)
                    state_d = S_COIN_REL;
                else if (wcnt_q == WCNT_W'(ACK_TIMEOUT - 1))
                    state_d = S_FAULT;
            end
            S_COIN_REL: begin
                if (!coin_ack)
                    state_d = (coins_left_q != 2'd0) ? S_COIN_REQ : S_IDLE;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, timers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mcnt_q       <= '0;
            wcnt_q       <= '0;
            coins_left_q <= 2'd0;
            motor_on     <= 1'b0;
            coin_req     <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            bad_code     <= 1'b0;
            fault        <= 1'b0;
            bottles_cnt  <= 8'd0;
            coins_cnt    <= 8'd0;
        end else begin
            state_q  <= state_d;
            motor_on <= (state_d == S_MOTOR);
            coin_req <= (state_d == S_COIN_REQ);
            busy     <= (state_d != S_IDLE) || (count_d != '0);
            overflow <= overflow | (event_c & full_c);
            bad_code <= bad_code | (change_i == 2'b11);
            fault    <= fault | (state_d == S_FAULT);

            mcnt_q <= (state_q == S_MOTOR) ? mcnt_q + MCNT_W'(1) : '0;
            wcnt_q <= (state_q == S_COIN_REQ) ? wcnt_q + WCNT_W'(1) : '0;

            if (pop_c)
                coins_left_q <= head_coins_c;

            if ((state_q == S_MOTOR) && (mcnt_q == MCNT_W'(MOTOR_CYCLES - 1)))
                bottles_cnt <= bottles_cnt + 8'd1;

            if ((state_q == S_COIN_REQ) && coin_ack) begin
                coins_cnt    <= coins_cnt + 8'd1;
                coins_left_q <= coins_left_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Bench for vm_dispense_ctrl: directed scenarios plus randomized traffic
// checked against a queue/service-time model of the dispenser.
module tb_vm_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend_i = 1'b0;
    logic [1:0] change_i = 2'b00;
    logic       coin_ack = 1'b0;
    logic       motor_on, coin_req, busy, overflow, bad_code, fault;
    logic [7:0] bottles_cnt, coins_cnt;

    vm_dispense_ctrl #(.FIFO_DEPTH(4), .MOTOR_CYCLES(8), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .vend_i(vend_i), .change_i(change_i), .coin_ack(coin_ack),
        .motor_on(motor_on), .coin_req(coin_req), .busy(busy), .overflow(overflow),
        .bad_code(bad_code), .fault(fault), .bottles_cnt(bottles_cnt), .coins_cnt(coins_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // hopper behaviour: 0 never acks, 1 mirrors coin_req, 2 acks 3 cycles after req
    int hop_mode = 1;
    int hop_dly = 0;

    // observation counters
    int mot_hi = 0;
    int req_hi = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    // reference model: event queue plus server free time
    int t = 0;
    bit model_en = 0;
    int q[$];
    int free_at = 0;
    int mot_start = -100;
    int exp_bottles = 0, exp_coins = 0;
    bit exp_ovf = 0, exp_bad = 0, exp_busy = 0, exp_motor = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        q.delete();
        free_at = 0;
        mot_start = -100;
        exp_bottles = 0; exp_coins = 0;
        exp_ovf = 0; exp_bad = 0; exp_busy = 0; exp_motor = 0;
    endtask

    // One clock edge of the model: a pop costs 1 + 8*vend + 2*coins cycles
    // with a mirroring hopper; fullness is judged before any same-edge pop.
    task automatic model_edge(input logic v, input logic [1:0] ch);
        int size0, e, ev, ec, nc;
        size0 = q.size();
        if (t >= free_at && size0 > 0) begin
            e = q.pop_front();
            ev = e / 4;
            ec = e % 4;
            free_at = t + 1 + 8 * ev + 2 * ec;
            if (ev != 0) mot_start = t;
            exp_bottles += ev;
            exp_coins += ec;
        end
        nc = (ch == 2'b01) ? 1 : (ch == 2'b10) ? 2 : 0;
        if (ch == 2'b11) exp_bad = 1;
        if (v || nc > 0) begin
            if (size0 < 4) q.push_back(int'(v) * 4 + nc);
            else exp_ovf = 1;
        end
        exp_busy = (t < free_at - 1) || (q.size() != 0);
        exp_motor = (t >= mot_start) && (t < mot_start + 8);
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        if (model_en) model_edge(vend_i, change_i);
        @(negedge clk);
        if (motor_on) mot_hi++;
        if (coin_req) req_hi++;
        if (coin_req && !req_prev) req_rises++;
        req_prev = coin_req;
        if (model_en) begin
            check("busy", int'(busy), int'(exp_busy));
            check("motor_on", int'(motor_on), int'(exp_motor));
        end
        case (hop_mode)
            1: coin_ack = coin_req;
            2: begin
                if (coin_ack) coin_ack = 1'b0;
                else if (coin_req) begin
                    hop_dly++;
                    if (hop_dly == 3) begin coin_ack = 1'b1; hop_dly = 0; end
                end else hop_dly = 0;
            end
            default: coin_ack = 1'b0;
        endcase
    endtask

    task automatic clear_obs();
        mot_hi = 0; req_hi = 0; req_rises = 0;
    endtask

    task automatic do_reset(input bit use_model, input int mode);
        vend_i = 1'b0; change_i = 2'b00; coin_ack = 1'b0; hop_dly = 0;
        model_en = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hop_mode = mode;
        req_prev = 1'b0;
        model_reset();
        model_en = use_model;
        clear_obs();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_motor"}, int'(motor_on), 0);
        check({tag, "_req"}, int'(coin_req), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_flags"}, int'({overflow, bad_code, fault}), 0);
        check({tag, "_bottles"}, int'(bottles_cnt), 0);
        check({tag, "_coins"}, int'(coins_cnt), 0);
    endtask

    task automatic idle_ticks(input int n);
        vend_i = 1'b0; change_i = 2'b00;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int first;
        int r;

        // reset state
        do_reset(1, 1);
        check_zero("reset");

        // 1) single vend: motor 8 cycles starting 2 cycles after the event
        vend_i = 1'b1; tick(); vend_i = 1'b0;
        check("t1_motor_at_capture", int'(motor_on), 0);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (motor_on && first < 0) first = i;
        end
        check("t1_first_motor", first, 1);
        check("t1_motor_len", mot_hi, 8);
        check("t1_bottles", int'(bottles_cnt), 1);
        check("t1_req_never", req_hi, 0);

        // 2) vend + 10rs with slow hopper
        do_reset(0, 2);
        vend_i = 1'b1; change_i = 2'b10; tick();
        first = -1;
        for (int i = 0; i < 80 && first < 0; i++) begin
            idle_ticks(1);
            if (!busy) first = i;
        end
        check("t2_drained", int'(first >= 0), 1);
        check("t2_motor_len", mot_hi, 8);
        check("t2_req_pulses", req_rises, 2);
        check("t2_coins", int'(coins_cnt), 2);
        check("t2_bottles", int'(bottles_cnt), 1);
        check("t2_busy", int'(busy), 0);

        // 3) six back-to-back vends against a 4-deep queue
        do_reset(1, 1);
        vend_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        idle_ticks(70);
        check("t3_overflow", int'(overflow), 1);
        check("t3_bottles", int'(bottles_cnt), 5);
        check("t3_busy", int'(busy), 0);

        // 4) hopper never acks: timeout fault, later events not served
        do_reset(0, 0);
        change_i = 2'b01; tick();
        idle_ticks(30);
        check("t4_req_len", req_hi, 16);
        check("t4_fault", int'(fault), 1);
        check("t4_req_low", int'(coin_req), 0);
        check("t4_coins", int'(coins_cnt), 0);
        clear_obs();
        vend_i = 1'b1; tick();
        idle_ticks(20);
        check("t4_no_motor", mot_hi, 0);
        check("t4_no_bottle", int'(bottles_cnt), 0);
        check("t4_fault_sticky", int'(fault), 1);

        // 5) illegal change code with vend
        do_reset(1, 1);
        vend_i = 1'b1; change_i = 2'b11; tick();
        idle_ticks(20);
        check("t5_bad_code", int'(bad_code), 1);
        check("t5_bottles", int'(bottles_cnt), 1);
        check("t5_coins", int'(coins_cnt), 0);
        check("t5_req_never", req_hi, 0);

        // 6) reset mid-motor (with a queued entry) and mid-handshake
        do_reset(0, 1);
        vend_i = 1'b1; tick(); tick(); vend_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t6_motor_4th", int'(motor_on), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero("t6a");
        clear_obs();
        idle_ticks(12);
        check("t6_fifo_cleared", mot_hi, 0);
        hop_mode = 0;
        change_i = 2'b01; tick(); change_i = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        check("t6_in_req", int'(coin_req), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero("t6b");

        // randomized traffic against the model
        do_reset(1, 1);
        for (int i = 0; i < 600; i++) begin
            vend_i = ($urandom_range(0, 99) < 25);
            r = int'($urandom_range(0, 99));
            change_i = (r < 70) ? 2'b00 : (r < 83) ? 2'b01 : (r < 96) ? 2'b10 : 2'b11;
            tick();
        end
        idle_ticks(300);
        check("rnd_bottles", int'(bottles_cnt), exp_bottles % 256);
        check("rnd_coins", int'(coins_cnt), exp_coins % 256);
        check("rnd_overflow", int'(overflow), int'(exp_ovf));
        check("rnd_bad_code", int'(bad_code), int'(exp_bad));
        check("rnd_fault", int'(fault), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
